// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
// Module : popcount_pkg
// Brief  : Shared widths, state encoding and helpers for popcount_seq_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
package popcount_pkg;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;
    localparam int SUM_W  = 13;
    localparam int CNT_W  = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

    function automatic logic [SUM_W-1:0] widen_count(input logic [CNT_W-1:0] cnt);
        return {{(SUM_W-CNT_W){1'b0}}, cnt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : popcount_seq_ctrl_if
// Brief  : Command, word stream and status bundle of popcount_seq_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
interface popcount_seq_ctrl_if;
    import popcount_pkg::*;

    logic              start;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [SUM_W-1:0]  sum;

    modport master (
        output start, len, in_data, in_valid,
        input  in_ready, busy, done, sum
    );

    modport slave (
        input  start, len, in_data, in_valid,
        output in_ready, busy, done, sum
    );

endinterface
`default_nettype wire

// File: rtl/popcount_16.sv
`default_nettype none
// ============================================================================
// Module : popcount_16
// Brief  : Combinational count of set bits in a 16-bit word (0..16).
// Rev    : 1.0  initial release
// ============================================================================
module popcount_16 (
    input  wire logic [15:0] data,
    output logic      [4:0]  count
);

    always_comb begin
        count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            count = count + {4'd0, data[i]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/popcount_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : popcount_seq_ctrl
// Brief  : Burst sequencer accumulating per-word popcounts into SUM.
// Rev    : 1.0  initial release
// ============================================================================
module popcount_seq_ctrl
    import popcount_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    popcount_seq_ctrl_if.slave bus
);

    state_t             r_state;
    state_t             w_next_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [SUM_W-1:0]   r_sum;
    logic [CNT_W-1:0]   w_count;
    logic               w_ready;
    logic               w_xfer;
    logic               w_accept_start;

    popcount_16 u_popcount_16 (
        .data  (bus.in_data),
        .count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_ready        = 1'b0;
        w_xfer         = 1'b0;
        w_accept_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept_start = 1'b1;
                    w_next_state   = (bus.len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                w_ready = 1'b1;
                w_xfer  = bus.in_valid;
                if (bus.in_valid && (r_remaining == LEN_W'(1))) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // A zero-length START loads remaining=0 and jumps straight to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
            r_sum       <= '0;
        end else if (w_accept_start) begin
            r_remaining <= bus.len;
            r_sum       <= '0;
        end else if (w_xfer) begin
            r_remaining <= r_remaining - LEN_W'(1);
            r_sum       <= r_sum + widen_count(w_count);
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.busy     = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.sum      = r_sum;

endmodule
`default_nettype wire
